// File: rtl/regbank_pkg.sv
// Shared types for the sequenced register bank: op codes, FSM states and
// the pair-op classifier used by the request checker.
package regbank_pkg;

  typedef enum logic [2:0] {
    OP_MOV8  = 3'd0,
    OP_LD8   = 3'd1,
    OP_ST8   = 3'd2,
    OP_LD16  = 3'd3,
    OP_ST16  = 3'd4,
    OP_INC16 = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_LOAD
  } state_e;

  function automatic logic is_pair_op(op_e op);
    return (op == OP_LD16) || (op == OP_ST16) || (op == OP_INC16);
  endfunction

endpackage

// File: rtl/register_bank_seq_if.sv
// Request port plus data/address bus taps of the register bank.
// master = sequencer/bus side, slave = the bank.
interface register_bank_seq_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
);
  localparam int IDXW = $clog2(NUM_REGS);

  logic                       req_valid;
  logic                       req_ready;
  logic [2:0]                 req_op;
  logic [IDXW-1:0]            req_src;
  logic [IDXW-1:0]            req_dst;
  logic [DATA_W-1:0]          data_bus_in;
  logic [DATA_W-1:0]          data_bus_out;
  logic                       data_bus_oe;
  logic [2*DATA_W-1:0]        addr_bus_in;
  logic [2*DATA_W-1:0]        addr_bus_out;
  logic                       addr_bus_oe;
  logic                       done;
  logic                       err;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;

  modport master (
    output req_valid, req_op, req_src, req_dst, data_bus_in, addr_bus_in,
    input  req_ready, data_bus_out, data_bus_oe, addr_bus_out, addr_bus_oe,
           done, err, regs_flat
  );

  modport slave (
    input  req_valid, req_op, req_src, req_dst, data_bus_in, addr_bus_in,
    output req_ready, data_bus_out, data_bus_oe, addr_bus_out, addr_bus_oe,
           done, err, regs_flat
  );
endinterface

// File: rtl/regbank_seq_ctrl.sv
// Select/settle/load sequencer: validates requests, latches operands and
// times the bus-select window with a settle down-counter.
module regbank_seq_ctrl
  import regbank_pkg::*;
#(
  parameter int NUM_REGS      = 8,
  parameter int NUM_PAIRS     = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDXW          = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reqValid,
  input  logic [2:0]      reqOp,
  input  logic [IDXW-1:0] reqSrc,
  input  logic [IDXW-1:0] reqDst,
  output logic            reqReady,
  output op_e             op,
  output logic [IDXW-1:0] src,
  output logic [IDXW-1:0] dst,
  output logic            selActive,
  output logic            loadEn,
  output logic            done,
  output logic            err
);

  localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_INIT =
    CNTW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_e          state, stateNxt;
  logic [CNTW-1:0] cnt;
  logic            reqOk, accept;

  function automatic logic idxOk(logic [IDXW-1:0] i, logic pair);
    return pair ? (int'(i) < NUM_PAIRS) : (int'(i) < NUM_REGS);
  endfunction

  // Only the operands an op actually uses are range-checked.
  always_comb begin
    reqOk = 1'b0;
    case (reqOp)
      OP_MOV8:                  reqOk = idxOk(reqSrc, 1'b0) && idxOk(reqDst, 1'b0);
      OP_LD8, OP_LD16, OP_INC16: reqOk = idxOk(reqDst, is_pair_op(op_e'(reqOp)));
      OP_ST8, OP_ST16:          reqOk = idxOk(reqSrc, is_pair_op(op_e'(reqOp)));
      default:                  reqOk = 1'b0;
    endcase
  end

  assign accept = (state == S_IDLE) && reqValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      op    <= OP_MOV8;
      src   <= '0;
      dst   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= stateNxt;
      done  <= (state == S_LOAD);
      err   <= accept && !reqOk;
      if (accept && reqOk) begin
        op  <= op_e'(reqOp);
        src <= reqSrc;
        dst <= reqDst;
        cnt <= CNT_INIT;
      end else if (state == S_SELECT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  always_comb begin
    stateNxt = state;
    case (state)
      S_IDLE:   if (accept && reqOk) stateNxt = (SETTLE_CYCLES == 0) ? S_LOAD : S_SELECT;
      S_SELECT: if (cnt == '0) stateNxt = S_LOAD;
      S_LOAD:   stateNxt = S_IDLE;
      default:  stateNxt = S_IDLE;
    endcase
  end

  always_comb begin
    reqReady  = (state == S_IDLE);
    selActive = (state == S_SELECT) || (state == S_LOAD);
    loadEn    = (state == S_LOAD);
  end

endmodule

// File: rtl/register_bank_seq.sv
// Parametrised register bank with byte registers and high-byte-first pairs
// on top; every transfer is sequenced select -> settle -> load.
module register_bank_seq
  import regbank_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int NUM_REGS      = 8,
  parameter int NUM_PAIRS     = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  register_bank_seq_if.slave  bus
);

  localparam int IDXW = $clog2(NUM_REGS);
  localparam int PB   = NUM_REGS - 2 * NUM_PAIRS;
  localparam logic [2*DATA_W-1:0] PAIR_ONE = 1;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  op_e                             op;
  logic [IDXW-1:0]                 src, dst;
  logic                            selActive, loadEn;
  logic [2*DATA_W-1:0]             srcPair, dstPair;

  regbank_seq_ctrl #(
    .NUM_REGS     (NUM_REGS),
    .NUM_PAIRS    (NUM_PAIRS),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .IDXW         (IDXW)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .reqValid (bus.req_valid),
    .reqOp    (bus.req_op),
    .reqSrc   (bus.req_src),
    .reqDst   (bus.req_dst),
    .reqReady (bus.req_ready),
    .op       (op),
    .src      (src),
    .dst      (dst),
    .selActive(selActive),
    .loadEn   (loadEn),
    .done     (bus.done),
    .err      (bus.err)
  );

  function automatic logic [IDXW-1:0] pairHi(logic [IDXW-1:0] p);
    return IDXW'(PB + 2 * int'(p));
  endfunction

  function automatic logic [IDXW-1:0] pairLo(logic [IDXW-1:0] p);
    return IDXW'(PB + 2 * int'(p) + 1);
  endfunction

  assign srcPair = {regs[pairHi(src)], regs[pairLo(src)]};
  assign dstPair = {regs[pairHi(dst)], regs[pairLo(dst)]};

  // Drives hold from the first select cycle through load; zero when idle.
  always_comb begin
    bus.data_bus_oe  = 1'b0;
    bus.data_bus_out = '0;
    bus.addr_bus_oe  = 1'b0;
    bus.addr_bus_out = '0;
    if (selActive) begin
      case (op)
        OP_MOV8, OP_ST8: begin
          bus.data_bus_oe  = 1'b1;
          bus.data_bus_out = regs[src];
        end
        OP_ST16: begin
          bus.addr_bus_oe  = 1'b1;
          bus.addr_bus_out = srcPair;
        end
        OP_INC16: begin
          bus.addr_bus_oe  = 1'b1;
          bus.addr_bus_out = dstPair;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (loadEn) begin
      case (op)
        OP_MOV8:  regs[dst] <= regs[src];
        OP_LD8:   regs[dst] <= bus.data_bus_in;
        OP_LD16:  {regs[pairHi(dst)], regs[pairLo(dst)]} <= bus.addr_bus_in;
        OP_INC16: {regs[pairHi(dst)], regs[pairLo(dst)]} <= dstPair + PAIR_ONE;
        default: ;
      endcase
    end
  end

  assign bus.regs_flat = regs;

endmodule

// File: tb/tb_register_bank_seq.sv
// Directed + randomized bench for register_bank_seq against a byte-array model.
module tb_register_bank_seq;

  localparam int SC = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  register_bank_seq_if #(.DATA_W(8), .NUM_REGS(8)) bi ();
  register_bank_seq_if #(.DATA_W(8), .NUM_REGS(8)) b0 ();

  register_bank_seq #(.DATA_W(8), .NUM_REGS(8), .NUM_PAIRS(2), .SETTLE_CYCLES(SC))
    dut (.clk(clk), .reset(reset), .bus(bi));
  register_bank_seq #(.DATA_W(8), .NUM_REGS(8), .NUM_PAIRS(2), .SETTLE_CYCLES(0))
    dut0 (.clk(clk), .reset(reset), .bus(b0));

  int errors = 0;
  int checks = 0;
  logic [7:0] m [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pairv(input int p);
    return {m[4 + 2 * p], m[5 + 2 * p]};
  endfunction

  function automatic logic [63:0] flatExp();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = m[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doOp(input logic [2:0] op, input int src, input int dst,
                      input logic [7:0] dbi, input logic [15:0] abi);
    logic        eDoe, eAoe;
    logic [7:0]  eDout;
    logic [15:0] eAout;
    eDoe = 1'b0; eAoe = 1'b0; eDout = '0; eAout = '0;
    case (op)
      3'd0, 3'd2: begin eDoe = 1'b1; eDout = m[src]; end
      3'd4:       begin eAoe = 1'b1; eAout = pairv(src); end
      3'd5:       begin eAoe = 1'b1; eAout = pairv(dst); end
      default: ;
    endcase
    bi.req_op = op; bi.req_src = 3'(src); bi.req_dst = 3'(dst);
    bi.data_bus_in = dbi; bi.addr_bus_in = abi; bi.req_valid = 1'b1;
    chk("accept_ready", 64'(bi.req_ready), 1);
    tick();
    // scramble request inputs: a busy bank must ignore them
    bi.req_valid = 1'b0;
    bi.req_op = 3'($urandom); bi.req_src = 3'($urandom); bi.req_dst = 3'($urandom);
    for (int c = 1; c <= SC + 1; c++) begin
      chk("busy_ready", 64'(bi.req_ready), 0);
      chk("busy_done", 64'(bi.done), 0);
      chk("busy_doe", 64'(bi.data_bus_oe), 64'(eDoe));
      chk("busy_dout", 64'(bi.data_bus_out), 64'(eDout));
      chk("busy_aoe", 64'(bi.addr_bus_oe), 64'(eAoe));
      chk("busy_aout", 64'(bi.addr_bus_out), 64'(eAout));
      tick();
    end
    case (op)
      3'd0: m[dst] = m[src];
      3'd1: m[dst] = dbi;
      3'd3: {m[4 + 2 * dst], m[5 + 2 * dst]} = abi;
      3'd5: {m[4 + 2 * dst], m[5 + 2 * dst]} = pairv(dst) + 16'd1;
      default: ;
    endcase
    chk("done_pulse", 64'(bi.done), 1);
    chk("done_ready", 64'(bi.req_ready), 1);
    chk("done_oe", 64'({bi.data_bus_oe, bi.addr_bus_oe}), 0);
    chk("done_outs", 64'({bi.data_bus_out, bi.addr_bus_out}), 0);
    chk("done_err", 64'(bi.err), 0);
    chk("regs", bi.regs_flat, flatExp());
  endtask

  task automatic badReq(input logic [2:0] op, input int src, input int dst);
    bi.req_op = op; bi.req_src = 3'(src); bi.req_dst = 3'(dst); bi.req_valid = 1'b1;
    chk("bad_ready", 64'(bi.req_ready), 1);
    tick();
    bi.req_valid = 1'b0;
    chk("bad_err", 64'(bi.err), 1);
    chk("bad_done", 64'(bi.done), 0);
    chk("bad_ready_after", 64'(bi.req_ready), 1);
    chk("bad_oe", 64'({bi.data_bus_oe, bi.addr_bus_oe}), 0);
    chk("bad_regs", bi.regs_flat, flatExp());
    tick();
    chk("bad_err_clear", 64'(bi.err), 0);
    chk("bad_done_later", 64'(bi.done), 0);
  endtask

  initial begin
    logic [7:0] v [3];
    int op, s, d;
    reset = 1'b1;
    bi.req_valid = 0; bi.req_op = 0; bi.req_src = 0; bi.req_dst = 0;
    bi.data_bus_in = 0; bi.addr_bus_in = 0;
    b0.req_valid = 0; b0.req_op = 0; b0.req_src = 0; b0.req_dst = 0;
    b0.data_bus_in = 0; b0.addr_bus_in = 0;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    tick(); tick();
    reset = 1'b0;

    chk("rst_regs", bi.regs_flat, 0);
    chk("rst_ready", 64'(bi.req_ready), 1);
    chk("rst_done_err", 64'({bi.done, bi.err}), 0);
    chk("rst_oe", 64'({bi.data_bus_oe, bi.addr_bus_oe}), 0);
    chk("rst_outs", 64'({bi.data_bus_out, bi.addr_bus_out}), 0);

    doOp(3'd1, 0, 0, 8'h5A, 16'h0);
    chk("ld8_r0", 64'(bi.regs_flat[7:0]), 64'h5A);
    doOp(3'd0, 0, 3, 8'h00, 16'h0);
    chk("mov8_r3", 64'(bi.regs_flat[31:24]), 64'h5A);
    doOp(3'd3, 0, 1, 8'h00, 16'hFFFF);
    doOp(3'd5, 0, 1, 8'h00, 16'h0);
    chk("inc16_wrap", 64'(bi.regs_flat[63:48]), 0);
    doOp(3'd1, 0, 4, 8'h12, 16'h0);
    doOp(3'd1, 0, 5, 8'h34, 16'h0);
    doOp(3'd4, 0, 0, 8'h00, 16'h0);
    doOp(3'd0, 2, 2, 8'h00, 16'h0);
    doOp(3'd2, 3, 0, 8'h00, 16'h0);

    badReq(3'd6, 0, 0);
    badReq(3'd7, 1, 1);
    badReq(3'd3, 0, 2);
    badReq(3'd4, 3, 0);
    badReq(3'd5, 0, 7);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: badReq(3'($urandom_range(6, 7)), $urandom_range(0, 7), $urandom_range(0, 7));
          1: badReq(3'd3, $urandom_range(0, 7), $urandom_range(2, 7));
          default: badReq(3'd4, $urandom_range(2, 7), $urandom_range(0, 7));
        endcase
      end else begin
        op = $urandom_range(0, 5);
        if (op >= 3) begin s = $urandom_range(0, 1); d = $urandom_range(0, 1); end
        else begin s = $urandom_range(0, 7); d = $urandom_range(0, 7); end
        doOp(3'(op), s, d, 8'($urandom), 16'($urandom));
      end
    end

    // reset while in SELECT: no write, no done
    bi.req_op = 3'd1; bi.req_src = 0; bi.req_dst = 3'd1;
    bi.data_bus_in = 8'hA5; bi.req_valid = 1'b1;
    tick();
    bi.req_valid = 1'b0;
    chk("mid_busy", 64'(bi.req_ready), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    chk("mid_rst_regs", bi.regs_flat, flatExp());
    chk("mid_rst_ready", 64'(bi.req_ready), 1);
    chk("mid_rst_done", 64'(bi.done), 0);
    tick();
    chk("mid_rst_done2", 64'(bi.done), 0);
    chk("mid_rst_regs2", bi.regs_flat, flatExp());
    tick();
    chk("mid_rst_done3", 64'(bi.done), 0);

    // zero-settle bank, back-to-back LD8 then MOV8
    chk("z_rst_regs", b0.regs_flat, 0);
    for (int k = 0; k < 3; k++) begin
      v[k] = 8'($urandom);
      b0.req_op = 3'd1; b0.req_dst = 3'(k); b0.data_bus_in = v[k]; b0.req_valid = 1'b1;
      chk("z_ready", 64'(b0.req_ready), 1);
      tick();
      b0.req_valid = 1'b0;
      chk("z_load_busy", 64'(b0.req_ready), 0);
      chk("z_load_done", 64'(b0.done), 0);
      tick();
      chk("z_done", 64'(b0.done), 1);
      chk("z_reg", 64'(b0.regs_flat[k*8 +: 8]), 64'(v[k]));
    end
    b0.req_op = 3'd0; b0.req_src = 3'd0; b0.req_dst = 3'd7; b0.req_valid = 1'b1;
    tick();
    b0.req_valid = 1'b0;
    chk("z_mov_doe", 64'(b0.data_bus_oe), 1);
    chk("z_mov_dout", 64'(b0.data_bus_out), 64'(v[0]));
    tick();
    chk("z_mov_done", 64'(b0.done), 1);
    chk("z_mov_r7", 64'(b0.regs_flat[63:56]), 64'(v[0]));
    chk("z_mov_oe_off", 64'(b0.data_bus_oe), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
